// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: shared FSM type, line codes and oversampling constants for the UART receive path.
package uart_receiver_pkg;
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_SAMPLE,
        RX_PARITY,
        RX_DONE,
        RX_CONFIG_REQ
    } receiver_fsm_e;
    localparam logic RX_LINE_IDLE = 1'b1;
    localparam int COUNT_10MS = 500_000;
    localparam int RX_OVERSAMPLE = 16;
    localparam int RX_SAMPLE_TICK = 7;
    localparam logic [1:0] DW_5BIT = 2'd0;
    localparam logic [1:0] DW_6BIT = 2'd1;
    localparam logic [1:0] DW_7BIT = 2'd2;
    localparam logic [1:0] DW_8BIT = 2'd3;
    localparam logic [1:0] PARITY_EVEN = 2'd0;
    localparam logic [1:0] PARITY_ODD = 2'd1;
    localparam logic [1:0] PARITY_DISABLED1 = 2'd2;
    localparam logic [1:0] PARITY_DISABLED2 = 2'd3;
    localparam logic [1:0] SB_1BIT = 2'd0;
    localparam logic [1:0] SB_2BIT = 2'd1;
    localparam logic [1:0] SB_RESERVED1 = 2'd2;
    localparam logic [1:0] SB_RESERVED2 = 2'd3;
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial input, frame configuration and received-word outputs of the UART receiver.
interface uart_receiver_if;
    logic rx_i;
    logic ov_tick_i;
    logic rx_enable_i;
    logic [1:0] data_width_i;
    logic [1:0] parity_mode_i;
    logic [1:0] stop_bits_i;
    logic [7:0] rx_data_o;
    logic rx_done_o;
    logic parity_error_o;
    logic frame_error_o;
    logic cfg_req_o;
    logic rx_idle_o;
    modport master (
        output rx_i, ov_tick_i, rx_enable_i, data_width_i, parity_mode_i, stop_bits_i,
        input rx_data_o, rx_done_o, parity_error_o, frame_error_o, cfg_req_o, rx_idle_o
    );
    modport slave (
        input rx_i, ov_tick_i, rx_enable_i, data_width_i, parity_mode_i, stop_bits_i,
        output rx_data_o, rx_done_o, parity_error_o, frame_error_o, cfg_req_o, rx_idle_o
    );
endinterface

// File: rtl/uart_rx_line_monitor.sv
// uart_rx_line_monitor: 2-flop RX synchroniser plus saturating low-time counter that flags a configuration request.
module uart_rx_line_monitor import uart_receiver_pkg::*; #(
    parameter int CFG_REQ_CYCLES = COUNT_10MS,
    parameter int LOW_CNT_WIDTH = $clog2(CFG_REQ_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic cfg_req_hit
);
    logic rx_meta;
    logic [LOW_CNT_WIDTH-1:0] low_cnt;
    always_ff @(posedge clk)
        if (rst) begin
            rx_meta <= RX_LINE_IDLE;
            rx_s <= RX_LINE_IDLE;
            low_cnt <= '0;
        end else begin
            rx_meta <= rx;
            rx_s <= rx_meta;
            low_cnt <= rx_s ? '0 : (&low_cnt ? low_cnt : low_cnt + LOW_CNT_WIDTH'(1));
        end
    // Counter runs past the threshold, so the hit lasts a single cycle per low period
    assign cfg_req_hit = low_cnt == LOW_CNT_WIDTH'(CFG_REQ_CYCLES - 1);
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART deserialiser with parity/frame checks and line-low config request.
// Optional: UART_RX_MAJORITY_VOTE_EN votes each bit over ticks 6/7/8 and samples at tick 8.
module uart_receiver import uart_receiver_pkg::*; #(
    parameter int CFG_REQ_CYCLES = COUNT_10MS,
    parameter int LOW_CNT_WIDTH = $clog2(CFG_REQ_CYCLES + 1)
) (
    input logic clk_i,
    input logic rst_i,
    uart_receiver_if.slave bus
);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] SAMPLE_PT = 4'(RX_SAMPLE_TICK + 1);
`else
    localparam logic [3:0] SAMPLE_PT = 4'(RX_SAMPLE_TICK);
`endif
    receiver_fsm_e state;
    logic rx_s, cfg_req_hit, bit_val, at_sample, at_boundary;
    logic p_err, f_err, stop_cnt, two_stop, last_stop;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [1:0] dw, pm;
    logic [7:0] data_reg;

    uart_rx_line_monitor #(
        .CFG_REQ_CYCLES(CFG_REQ_CYCLES),
        .LOW_CNT_WIDTH(LOW_CNT_WIDTH)
    ) u_line_monitor (
        .clk(clk_i),
        .rst(rst_i),
        .rx(bus.rx_i),
        .rx_s(rx_s),
        .cfg_req_hit(cfg_req_hit)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] VOTE_A = SAMPLE_PT - 4'd2;
    localparam logic [3:0] VOTE_B = SAMPLE_PT - 4'd1;
    logic [1:0] early;
    always_ff @(posedge clk_i)
        if (rst_i) early <= {2{RX_LINE_IDLE}};
        else if (bus.ov_tick_i && (tick_cnt == VOTE_A || tick_cnt == VOTE_B)) early <= {early[0], rx_s};
    assign bit_val = (early[1] & early[0]) | (early[1] & rx_s) | (early[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign at_sample = bus.ov_tick_i && tick_cnt == SAMPLE_PT;
    assign at_boundary = bus.ov_tick_i && &tick_cnt;
    assign last_stop = !two_stop || stop_cnt;

    always_ff @(posedge clk_i)
        if (rst_i) begin
            state <= RX_IDLE;
            tick_cnt <= '0;
            bit_cnt <= '0;
            stop_cnt <= 1'b0;
            dw <= DW_5BIT;
            pm <= PARITY_EVEN;
            two_stop <= 1'b0;
            data_reg <= '0;
            p_err <= 1'b0;
            f_err <= 1'b0;
            bus.rx_data_o <= '0;
            bus.rx_done_o <= 1'b0;
            bus.parity_error_o <= 1'b0;
            bus.frame_error_o <= 1'b0;
            bus.cfg_req_o <= 1'b0;
            bus.rx_idle_o <= 1'b1;
        end else begin
            bus.rx_done_o <= 1'b0;
            bus.parity_error_o <= 1'b0;
            bus.frame_error_o <= 1'b0;
            bus.cfg_req_o <= 1'b0;
            if (bus.ov_tick_i) tick_cnt <= tick_cnt + 4'd1;
            // A long line-low wins over everything, including a frame finishing this cycle
            if (cfg_req_hit && state != RX_CONFIG_REQ) begin
                state <= RX_CONFIG_REQ;
                bus.cfg_req_o <= 1'b1;
                bus.rx_idle_o <= 1'b0;
            end else begin
                case (state)
                    RX_IDLE:
                        if (bus.rx_enable_i && !rx_s) begin
                            state <= RX_START;
                            bus.rx_idle_o <= 1'b0;
                            tick_cnt <= '0;
                            bit_cnt <= '0;
                            stop_cnt <= 1'b0;
                            dw <= bus.data_width_i;
                            pm <= bus.parity_mode_i;
                            two_stop <= bus.stop_bits_i == SB_2BIT;
                            data_reg <= '0;
                            p_err <= 1'b0;
                            f_err <= 1'b0;
                        end
                    RX_START:
                        if (at_sample && bit_val) begin
                            state <= RX_IDLE;
                            bus.rx_idle_o <= 1'b1;
                        end else if (at_boundary) state <= RX_SAMPLE;
                    RX_SAMPLE: begin
                        if (at_sample) data_reg[bit_cnt] <= bit_val;
                        if (at_boundary) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == {1'b1, dw}) state <= pm[1] ? RX_DONE : RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        if (at_sample) p_err <= (^data_reg ^ bit_val) != (pm == PARITY_ODD);
                        if (at_boundary) state <= RX_DONE;
                    end
                    RX_DONE:
                        // Leave mid-stop-bit so a back-to-back start edge is caught
                        if (at_sample) begin
                            f_err <= f_err | ~bit_val;
                            if (last_stop) begin
                                state <= RX_IDLE;
                                bus.rx_idle_o <= 1'b1;
                                bus.rx_data_o <= data_reg;
                                bus.rx_done_o <= 1'b1;
                                bus.parity_error_o <= p_err;
                                bus.frame_error_o <= f_err | ~bit_val;
                            end
                        end else if (at_boundary) stop_cnt <= 1'b1;
                    RX_CONFIG_REQ:
                        if (rx_s) begin
                            state <= RX_IDLE;
                            bus.rx_idle_o <= 1'b1;
                        end
                    default: begin
                        state <= RX_IDLE;
                        bus.rx_idle_o <= 1'b1;
                    end
                endcase
            end
        end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames into uart_receiver, one tick per 4 clocks, config request at 1000 cycles.
`timescale 1ns/1ps
module tb_uart_receiver;
    import uart_receiver_pkg::*;
    localparam int BIT_CLKS = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_en = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int cfg_cnt = 0;
    int d0, c0;
    logic [7:0] last_data = '0;
    logic last_perr = 1'b0;
    logic last_ferr = 1'b0;

    uart_receiver_if bus();
    uart_receiver #(.CFG_REQ_CYCLES(1000)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        bus.ov_tick_i = 1'b0;
        forever
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                bus.ov_tick_i = tick_en && i == 0;
            end
    end

    always @(negedge clk) begin
        if (bus.rx_done_o) begin
            done_cnt++;
            last_data = bus.rx_data_o;
            last_perr = bus.parity_error_o;
            last_ferr = bus.frame_error_o;
        end
        if (bus.cfg_req_o) cfg_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx_i = v[i];
            cycles(BIT_CLKS);
        end
        bus.rx_i = 1'b1;
    endtask

    task automatic set_cfg(input logic [1:0] dw, input logic [1:0] pm, input logic [1:0] sb);
        bus.data_width_i = dw;
        bus.parity_mode_i = pm;
        bus.stop_bits_i = sb;
    endtask

    task automatic chk_frame(input string tag, input int n, input logic [7:0] d, input logic pe, input logic fe);
        chk({tag, "_done"}, done_cnt - d0, n);
        chk({tag, "_data"}, last_data, d);
        chk({tag, "_perr"}, last_perr, pe);
        chk({tag, "_ferr"}, last_ferr, fe);
    endtask

    initial begin
        bus.rx_i = 1'b1;
        bus.rx_enable_i = 1'b1;
        set_cfg(DW_8BIT, PARITY_EVEN, SB_1BIT);
        cycles(3);
        chk("rst_data", bus.rx_data_o, 8'h00);
        chk("rst_done", bus.rx_done_o, 1'b0);
        chk("rst_perr", bus.parity_error_o, 1'b0);
        chk("rst_ferr", bus.frame_error_o, 1'b0);
        chk("rst_cfg", bus.cfg_req_o, 1'b0);
        chk("rst_idle", bus.rx_idle_o, 1'b1);
        rst = 1'b0;
        cycles(BIT_CLKS);

        // 8-bit even: 0xA5 has four ones, parity bit 0
        d0 = done_cnt;
        send({1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        cycles(BIT_CLKS);
        chk_frame("t1", 1, 8'hA5, 1'b0, 1'b0);

        // 7-bit odd: 0x35 has four ones, so parity bit 0 is the wrong one
        set_cfg(DW_7BIT, PARITY_ODD, SB_1BIT);
        d0 = done_cnt;
        send({1'b1, 1'b0, 7'h35, 1'b0}, 10);
        cycles(BIT_CLKS);
        chk_frame("t2", 1, 8'h35, 1'b1, 1'b0);

        // 5-bit, 2 stop, second stop low; enable dropped mid-frame
        set_cfg(DW_5BIT, PARITY_DISABLED1, SB_2BIT);
        d0 = done_cnt;
        send({5'h1F, 1'b0}, 6);
        bus.rx_enable_i = 1'b0;
        send({1'b0, 1'b1}, 2);
        cycles(BIT_CLKS);
        chk_frame("t3", 1, 8'h1F, 1'b0, 1'b1);
        chk("t3_idle", bus.rx_idle_o, 1'b1);
        bus.rx_enable_i = 1'b1;
        cycles(BIT_CLKS);

        // 4-tick start glitch, then a clean 0x16 frame
        set_cfg(DW_8BIT, PARITY_DISABLED1, SB_1BIT);
        d0 = done_cnt;
        bus.rx_i = 1'b0;
        cycles(12);
        chk("t4_start_seen", bus.rx_idle_o, 1'b0);
        cycles(4);
        bus.rx_i = 1'b1;
        cycles(BIT_CLKS);
        chk("t4_glitch_idle", bus.rx_idle_o, 1'b1);
        chk("t4_glitch_nodone", done_cnt - d0, 0);
        send({1'b1, 8'h16, 1'b0}, 10);
        cycles(BIT_CLKS);
        chk_frame("t4", 1, 8'h16, 1'b0, 1'b0);

        // Line held low mid-frame with ticks stopped: config request aborts the frame
        d0 = done_cnt;
        c0 = cfg_cnt;
        send({2'b11, 1'b0}, 3);
        tick_en = 1'b0;
        bus.rx_i = 1'b0;
        cycles(1100);
        chk("t5_cfg_once", cfg_cnt - c0, 1);
        chk("t5_nodone", done_cnt - d0, 0);
        chk("t5_in_cfg", bus.rx_idle_o, 1'b0);
        bus.rx_i = 1'b1;
        cycles(1);
        chk("t5_still_cfg", bus.rx_idle_o, 1'b0);
        cycles(2);
        chk("t5_idle", bus.rx_idle_o, 1'b1);
        tick_en = 1'b1;
        cycles(BIT_CLKS);
        chk("t5_cfg_after", cfg_cnt - c0, 1);
        chk("t5_nodone_after", done_cnt - d0, 0);

        // Reset during data bit 3, then a clean 0x5A frame
        d0 = done_cnt;
        send({3'b101, 1'b0}, 4);
        bus.rx_i = 1'b0;
        cycles(32);
        rst = 1'b1;
        cycles(1);
        chk("t6_rst_data", bus.rx_data_o, 8'h00);
        chk("t6_rst_idle", bus.rx_idle_o, 1'b1);
        chk("t6_rst_done", bus.rx_done_o, 1'b0);
        rst = 1'b0;
        bus.rx_i = 1'b1;
        cycles(2 * BIT_CLKS);
        chk("t6_partial_dropped", done_cnt - d0, 0);
        send({1'b1, 8'h5A, 1'b0}, 10);
        cycles(BIT_CLKS);
        chk_frame("t6", 1, 8'h5A, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
